// File: rtl/bcd_counter_n.sv
// ----------------------------------------------------------------------------
// bcd_counter_n
// Parametrised N-digit BCD up/down counter with synchronous parallel load,
// wrap or saturate behaviour at the limits, and registered carry/borrow pulses.
//
// Parameters
//   DIGITS     number of BCD digits (1..8)
//   SATURATE   0 = wrap at the limits, 1 = hold at the limits
// Ports
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   count_en    count one step this cycle
//   up          direction: 1 = increment, 0 = decrement
//   load        synchronous load of load_value (priority over count_en)
//   load_value  BCD value to load, digit k at [4k+3:4k]; nibbles >9 load as 9
//   digits      current count, BCD, units in [3:0]
//   carry       one-cycle pulse on an up-count from all-nines
//   borrow      one-cycle pulse on a down-count from all-zeros
//   is_zero     high while every digit is 0 (decoded from the count register)
// ----------------------------------------------------------------------------
module bcd_counter_n #(
    parameter int unsigned DIGITS   = 4,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  count_en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  carry,
    output logic                  borrow,
    output logic                  is_zero
);

    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0] digits_q, digits_d;
    logic         carry_q,  carry_d;
    logic         borrow_q, borrow_d;

    logic [W-1:0] inc_c;
    logic [W-1:0] dec_c;
    logic [W-1:0] load_c;
    logic         inc_ripple_c;
    logic         dec_ripple_c;
    logic [3:0]   nib_c;
    logic [3:0]   lv_nib_c;

    // Per-digit increment/decrement with the carry rippling from the units up.
    // A ripple that survives past the top digit means all-nines / all-zeros.
    always_comb begin
        inc_c        = '0;
        dec_c        = '0;
        load_c       = '0;
        inc_ripple_c = 1'b1;
        dec_ripple_c = 1'b1;
        nib_c        = '0;
        lv_nib_c     = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            nib_c = digits_q[4*k +: 4];

            if (!inc_ripple_c) begin
                inc_c[4*k +: 4] = nib_c;
            end else if (nib_c >= 4'd9) begin
                inc_c[4*k +: 4] = 4'd0;
            end else begin
                inc_c[4*k +: 4] = 4'(nib_c + 4'd1);
                inc_ripple_c    = 1'b0;
            end

            if (!dec_ripple_c) begin
                dec_c[4*k +: 4] = nib_c;
            end else if (nib_c == 4'd0) begin
                dec_c[4*k +: 4] = 4'd9;
            end else begin
                dec_c[4*k +: 4] = 4'(nib_c - 4'd1);
                dec_ripple_c    = 1'b0;
            end

            // Clamp out-of-range load nibbles so no digit can ever exceed 9.
            lv_nib_c        = load_value[4*k +: 4];
            load_c[4*k +: 4] = (lv_nib_c > 4'd9) ? 4'd9 : lv_nib_c;
        end
    end

    // Next-state selection: load, then count up, then count down, else hold.
    always_comb begin
        digits_d = digits_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        if (load) begin
            digits_d = load_c;
        end else if (count_en) begin
            if (up) begin
                carry_d  = inc_ripple_c;
                digits_d = (inc_ripple_c && SATURATE) ? digits_q : inc_c;
            end else begin
                borrow_d = dec_ripple_c;
                digits_d = (dec_ripple_c && SATURATE) ? digits_q : dec_c;
            end
        end
    end

    // Count and pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digits_q <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            digits_q <= digits_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    assign digits  = digits_q;
    assign carry   = carry_q;
    assign borrow  = borrow_q;
    assign is_zero = (digits_q == '0);

endmodule

// File: tb/tb_bcd_counter_n.sv
// ----------------------------------------------------------------------------
// tb_bcd_counter_n
// Drives three counter configurations from shared controls
// (2 digits wrap, 4 digits wrap, 2 digits saturate) and compares each against
// an integer-valued reference model every cycle, plus directed checks.
// ----------------------------------------------------------------------------
module tb_bcd_counter_n;

    localparam int unsigned NI = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        count_en;
    logic        up;
    logic        load;
    logic [31:0] load_value;

    logic [7:0]  d0;
    logic [15:0] d1;
    logic [7:0]  d2;
    logic        c0, c1, c2, b0, b1, b2, z0, z1, z2;

    always #5 clk = ~clk;

    bcd_counter_n #(.DIGITS(2), .SATURATE(1'b0)) u0 (
        .clk(clk), .reset_n(reset_n), .count_en(count_en), .up(up), .load(load),
        .load_value(load_value[7:0]), .digits(d0), .carry(c0), .borrow(b0), .is_zero(z0)
    );
    bcd_counter_n #(.DIGITS(4), .SATURATE(1'b0)) u1 (
        .clk(clk), .reset_n(reset_n), .count_en(count_en), .up(up), .load(load),
        .load_value(load_value[15:0]), .digits(d1), .carry(c1), .borrow(b1), .is_zero(z1)
    );
    bcd_counter_n #(.DIGITS(2), .SATURATE(1'b1)) u2 (
        .clk(clk), .reset_n(reset_n), .count_en(count_en), .up(up), .load(load),
        .load_value(load_value[7:0]), .digits(d2), .carry(c2), .borrow(b2), .is_zero(z2)
    );

    logic [31:0] dut_dig [NI];
    logic        dut_c   [NI];
    logic        dut_b   [NI];
    logic        dut_z   [NI];
    assign dut_dig[0] = 32'(d0);
    assign dut_dig[1] = 32'(d1);
    assign dut_dig[2] = 32'(d2);
    assign dut_c[0] = c0;  assign dut_c[1] = c1;  assign dut_c[2] = c2;
    assign dut_b[0] = b0;  assign dut_b[1] = b1;  assign dut_b[2] = b2;
    assign dut_z[0] = z0;  assign dut_z[1] = z1;  assign dut_z[2] = z2;

    // Reference model: count held as a plain integer in [0, 10^DIGITS).
    int ndig [NI] = '{2, 4, 2};
    bit msat [NI] = '{1'b0, 1'b0, 1'b1};
    int mval [NI];
    bit mc   [NI];
    bit mb   [NI];

    int n_checks = 0;
    int n_fail   = 0;
    int obs_carry  [NI];
    int obs_borrow [NI];

    function automatic int pow10(input int d);
        int p = 1;
        for (int k = 0; k < d; k++) p = p * 10;
        return p;
    endfunction

    function automatic logic [31:0] to_bcd(input int v, input int d);
        logic [31:0] r = '0;
        int t = v;
        for (int k = 0; k < d; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int clamp_val(input logic [31:0] lv, input int d);
        int v = 0;
        int p = 1;
        int nib;
        for (int k = 0; k < d; k++) begin
            nib = int'(lv[4*k +: 4]);
            if (nib > 9) nib = 9;
            v = v + nib * p;
            p = p * 10;
        end
        return v;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            mval[i] = 0; mc[i] = 1'b0; mb[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        int lim;
        for (int i = 0; i < NI; i++) begin
            lim = pow10(ndig[i]);
            mc[i] = 1'b0;
            mb[i] = 1'b0;
            if (load) begin
                mval[i] = clamp_val(load_value, ndig[i]);
            end else if (count_en && up) begin
                if (mval[i] == lim - 1) begin
                    mc[i] = 1'b1;
                    if (!msat[i]) mval[i] = 0;
                end else begin
                    mval[i] = mval[i] + 1;
                end
            end else if (count_en) begin
                if (mval[i] == 0) begin
                    mb[i] = 1'b1;
                    if (!msat[i]) mval[i] = lim - 1;
                end else begin
                    mval[i] = mval[i] - 1;
                end
            end
        end
    endtask

    task automatic check_all(input string where);
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("%s u%0d digits", where, i), dut_dig[i], to_bcd(mval[i], ndig[i]));
            check_eq($sformatf("%s u%0d carry", where, i), 32'(dut_c[i]), 32'(mc[i]));
            check_eq($sformatf("%s u%0d borrow", where, i), 32'(dut_b[i]), 32'(mb[i]));
            check_eq($sformatf("%s u%0d is_zero", where, i), 32'(dut_z[i]), 32'(mval[i] == 0));
        end
    endtask

    // One clock: model consumes the current inputs, DUT sampled 1ns after the edge.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            obs_carry[i]  += int'(dut_c[i]);
            obs_borrow[i] += int'(dut_b[i]);
        end
        check_all("cyc");
    endtask

    task automatic run(input int n);
        for (int j = 0; j < n; j++) step();
    endtask

    task automatic clear_obs();
        for (int i = 0; i < NI; i++) begin
            obs_carry[i] = 0; obs_borrow[i] = 0;
        end
    endtask

    task automatic load_val(input logic [31:0] v);
        load = 1'b1; count_en = 1'b0; load_value = v;
        step();
        load = 1'b0;
    endtask

    // Reset pulse placed between edges; outputs must clear without a clock.
    task automatic async_reset(input string tag);
        #3;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("%s u%0d digits", tag, i), dut_dig[i], 32'h0);
            check_eq($sformatf("%s u%0d carry", tag, i), 32'(dut_c[i]), 32'h0);
            check_eq($sformatf("%s u%0d borrow", tag, i), 32'(dut_b[i]), 32'h0);
            check_eq($sformatf("%s u%0d is_zero", tag, i), 32'(dut_z[i]), 32'h1);
        end
        model_reset();
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int r;
        reset_n = 1'b0; count_en = 1'b0; up = 1'b1; load = 1'b0; load_value = '0;
        model_reset();
        clear_obs();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset_n = 1'b1;

        // Reset and first count-up.
        count_en = 1'b1; up = 1'b1;
        run(9);
        check_eq("t1 after 9", dut_dig[0], 32'h09);
        run(1);
        check_eq("t1 after 10", dut_dig[0], 32'h10);
        check_eq("t1 carry count", 32'(obs_carry[0]), 32'd0);

        // Wrap up (2 digits).
        load_val(32'h0);
        clear_obs();
        count_en = 1'b1; up = 1'b1;
        run(99);
        check_eq("t2 at 99", dut_dig[0], 32'h99);
        run(1);
        check_eq("t2 wrap", dut_dig[0], 32'h00);
        check_eq("t2 carry pulse", 32'(dut_c[0]), 32'h1);
        run(12);
        check_eq("t2 at 12", dut_dig[0], 32'h12);
        check_eq("t2 carry count", 32'(obs_carry[0]), 32'd1);

        // Wrap down (4 digits).
        load_val(32'h0);
        clear_obs();
        count_en = 1'b1; up = 1'b0;
        run(1);
        check_eq("t3 wrap", dut_dig[1], 32'h9999);
        check_eq("t3 borrow pulse", 32'(dut_b[1]), 32'h1);
        run(9999);
        check_eq("t3 back to 0", dut_dig[1], 32'h0000);
        check_eq("t3 borrow count", 32'(obs_borrow[1]), 32'd1);

        // Load with count_en in the same cycle; F nibble clamps to 9.
        load = 1'b1; count_en = 1'b1; up = 1'b1; load_value = 32'h0000_12F4;
        step();
        check_eq("t4 load 4d", dut_dig[1], 32'h1294);
        check_eq("t4 load 2d", dut_dig[0], 32'h94);
        load = 1'b0;
        step();
        check_eq("t4 count", dut_dig[1], 32'h1295);

        // Saturate at both limits.
        load_val(32'h98);
        count_en = 1'b1; up = 1'b1;
        step();
        check_eq("t5 up1 val", dut_dig[2], 32'h99);
        check_eq("t5 up1 carry", 32'(dut_c[2]), 32'h0);
        step();
        check_eq("t5 up2 val", dut_dig[2], 32'h99);
        check_eq("t5 up2 carry", 32'(dut_c[2]), 32'h1);
        step();
        check_eq("t5 up3 val", dut_dig[2], 32'h99);
        check_eq("t5 up3 carry", 32'(dut_c[2]), 32'h1);
        load_val(32'h01);
        count_en = 1'b1; up = 1'b0;
        step();
        check_eq("t5 dn1 val", dut_dig[2], 32'h00);
        check_eq("t5 dn1 borrow", 32'(dut_b[2]), 32'h0);
        step();
        check_eq("t5 dn2 val", dut_dig[2], 32'h00);
        check_eq("t5 dn2 borrow", 32'(dut_b[2]), 32'h1);
        step();
        check_eq("t5 dn3 val", dut_dig[2], 32'h00);
        check_eq("t5 dn3 borrow", 32'(dut_b[2]), 32'h1);

        // Async reset while a carry pulse is high, then mid-count at 0x57.
        load_val(32'h99);
        count_en = 1'b1; up = 1'b1;
        step();
        async_reset("t6 rst carry");
        load_val(32'h57);
        count_en = 1'b1; up = 1'b1;
        async_reset("t6 rst mid");
        step();
        check_eq("t6 resume", dut_dig[0], 32'h01);

        // Randomized traffic, biased toward counting with occasional loads.
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 99));
            load       = (r < 6);
            count_en   = (r < 90);
            up         = 1'($urandom);
            load_value = $urandom;
            if (r < 2) load_value = 32'h9999_9999;
            else if (r < 4) load_value = 32'h0;
            step();
        end
        load = 1'b0; count_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_counter_n.md
# bcd_counter_n

Parametrised N-digit BCD counter. It is the next generation of the fixed two-digit count-enable counter, and adds:
- configurable digit count;
- up/down direction;
- synchronous parallel load;
- selectable wrap or saturate mode;
- registered carry and borrow pulses.

It sits between user input logic (buttons, prescaled ticks) and the seven-segment display multiplexer, and feeds `digits` directly to the display decoder.

## Interface
- `DIGITS`, default 4: number of BCD digits, 1..8.
- `SATURATE`, default 0: 0 = wrap at the limits; 1 = hold at the limits.
- `clk` in 1: system clock; all state changes on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset; release is synchronous to `clk` by the surrounding design.
- `count_en` in 1: count one step this cycle when high.
- `up` in 1: direction. 1 = increment, 0 = decrement. Sampled only when `count_en` is high.
- `load` in 1: synchronous load of `load_value`. Has priority over `count_en`.
- `load_value` in 4*DIGITS: BCD value to load. Digit k occupies bits [4k+3:4k].
- `digits` out 4*DIGITS: current count, BCD. Digit 0 (units) is in [3:0].
- `carry` out 1: one-cycle pulse on an up-count from all-nines.
- `borrow` out 1: one-cycle pulse on a down-count from all-zeros.
- `is_zero` out 1: high while every digit is 0. Combinational from the `digits` register.

## Operation
- Reset (`reset_n`=0), asynchronous: `digits`=0, `carry`=0, `borrow`=0; `is_zero` therefore 1.
- Each cycle, evaluated in priority order:
  1. `load`=1: each digit takes its `load_value` nibble. Any nibble >9 is loaded as 9. `carry` and `borrow` go to 0. `count_en` is ignored.
  2. `count_en`=1, `up`=1:
     - Units digit increments.
     - A digit at 9 becomes 0 and increments the next digit (ripple within the same cycle).
     - All-nines with `SATURATE`=0: all digits become 0 and `carry`=1 for one cycle.
     - All-nines with `SATURATE`=1: count holds at all-nines and `carry`=1 for one cycle.
  3. `count_en`=1, `up`=0:
     - Units digit decrements.
     - A digit at 0 becomes 9 and decrements the next digit.
     - All-zeros with `SATURATE`=0: all digits become 9 and `borrow`=1 for one cycle.
     - All-zeros with `SATURATE`=1: count holds at 0 and `borrow`=1.
  4. Otherwise the count holds and `carry`=`borrow`=0.
- `carry` and `borrow` are registered and are never high in the same cycle.
- In saturate mode, repeated counting at a limit gives one pulse per enabled cycle.
- No digit ever holds a value >9 under any input sequence.
- Width rule: the internal state is exactly 4*DIGITS bits. There is no binary shadow counter.

## Timing
- Latency: 1 clock. Inputs sampled at edge N appear on `digits`, `carry` and `borrow` after edge N.
- `carry`/`borrow` are asserted in the same cycle that `digits` first shows the wrapped (or held) value.
- Holding `count_en`=1 for n cycles advances the count by exactly n, modulo 10^DIGITS.
- `load` and `count_en` high together: load wins, with no count applied to the loaded value that cycle.
- `up` changes between cycles are allowed with no penalty. Direction takes effect on the same edge it is sampled.
- `reset_n` asserted mid-count clears `digits` and the pulses immediately, without waiting for a clock edge.
- First enabled count occurs on the first rising edge after `reset_n` deasserts.

## Test plan
1. **Reset and first count-up** (DIGITS=2, SATURATE=0).
   - Stimulus: reset, then 9 enabled up-counts, then 1 more.
   - Required: `digits`=0x09 after 9 counts, then 0x10. `carry` never pulses. `is_zero`=1 only immediately after reset.
2. **Wrap up.**
   - Stimulus: 99 up-counts from 0, then 1 more, then 12 more.
   - Required: `digits`=0x99, then 0x00 with exactly one `carry` pulse, then 0x12. Total `carry` pulses = 1.
3. **Wrap down** (DIGITS=4).
   - Stimulus: from 0, 1 down-count, then 9999 further down-counts.
   - Required: `digits`=0x9999 with exactly one `borrow` pulse, then 0x0000. Total `borrow` pulses = 1.
4. **Load.**
   - Stimulus: `load_value`=0x12F4 with `load`=1 and `count_en`=1 in the same cycle.
   - Required: `digits`=0x1294 next cycle (F clamped to 9, no count applied). Next up-count gives 0x1295.
5. **Saturate** (SATURATE=1, DIGITS=2).
   - Stimulus part 1: load 0x98, then 3 up-counts.
   - Required: 0x99 is held; `carry` is high on the 2nd and 3rd counts only.
   - Stimulus part 2: load 0x01, then 3 down-counts.
   - Required: 0x00 is held; `borrow` is high on the 2nd and 3rd counts only.
6. **Async reset mid-count.**
   - Stimulus: pulse `reset_n` low between clock edges while `count_en`=1 at count 0x57.
   - Required: `digits`=0 and `carry`=`borrow`=0 before the next edge. Counting resumes at 0x01 after release.
